// File: rtl/best_neighbor_scan_pkg.sv
// Shared memory map, word widths and scan FSM encoding for the neighbour-table scanner.
// The winner-selection logic reads the same map, so these constants live here and nowhere else.
package best_neighbor_scan_pkg;

    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 11;
    localparam int MAX_NBR = 16;
    localparam int CNT_W   = 5;

    localparam logic [ADDR_W-1:0] NBR_CNT_ADDR = 11'h606;
    localparam logic [ADDR_W-1:0] NBR_BASE     = 11'h608;
    localparam logic [ADDR_W-1:0] BETTER_BASE  = 11'h668;
    localparam logic [ADDR_W-1:0] BETTER_CNT   = 11'h68C;
    localparam logic [ADDR_W-1:0] EPSILON      = 11'h4;

    localparam logic [WORD_W-1:0] NO_HOP = 16'd301;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_CNT_A  = 4'd1;
    localparam state_t ST_CNT_RD = 4'd2;
    localparam state_t ST_ID_A   = 4'd3;
    localparam state_t ST_ID_RD  = 4'd4;
    localparam state_t ST_VAL_A  = 4'd5;
    localparam state_t ST_VAL_RD = 4'd6;
    localparam state_t ST_BID_A  = 4'd7;
    localparam state_t ST_BID_RD = 4'd8;
    localparam state_t ST_EVAL   = 4'd9;
    localparam state_t ST_WR_L   = 4'd10;
    localparam state_t ST_NEXT   = 4'd11;
    localparam state_t ST_WR_C   = 4'd12;
    localparam state_t ST_DONE   = 4'd13;

    // Entry i occupies three words starting at NBR_BASE + 6*i.
    function automatic logic [ADDR_W-1:0] entry_addr(input logic [CNT_W-1:0] idx);
        return NBR_BASE + ADDR_W'(idx) * 11'd6;
    endfunction

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [CNT_W-1:0] slot);
        return BETTER_BASE + {5'b0, slot, 1'b0};
    endfunction

endpackage

// File: rtl/best_neighbor_scan_if.sv
// Shared-memory port of the scanner: registered byte address, write word/strobe, read word.
// No handshake: data_in must reflect address one cycle after it changes; wr_en is a one-cycle write of data_out.
interface best_neighbor_scan_if;
    import best_neighbor_scan_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] data_out;
    logic              wr_en;
    logic [WORD_W-1:0] data_in;

    modport master (output address, output data_out, output wr_en, input data_in);
    modport slave  (input address, input data_out, input wr_en, output data_in);

endinterface

// File: rtl/best_neighbor_scan.sv
// Walks the neighbour table, tracks the highest-value entry and lists every neighbour beating mybest.
// One FSM; each table word costs an address cycle and a sample cycle.
module best_neighbor_scan
    import best_neighbor_scan_pkg::*;
(
    input  logic                 clock,
    input  logic                 nrst,
    input  logic                 start_scan,
    input  logic [WORD_W-1:0]    mybest,
    input  logic [WORD_W-1:0]    MY_NODE_ID,
    best_neighbor_scan_if.master mem,
    output logic [WORD_W-1:0]    besthop,
    output logic [WORD_W-1:0]    bestvalue,
    output logic [WORD_W-1:0]    bestneighborID,
    output logic [WORD_W-1:0]    betterNeighborCount,
    output logic                 done_scan,
    output state_t               state_dbg
);

    state_t            state;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  i;
    logic [CNT_W-1:0]  k;
    logic [WORD_W-1:0] cur_id;
    logic [WORD_W-1:0] cur_val;
    logic [WORD_W-1:0] cur_bid;
    logic [CNT_W-1:0]  n_clamped;

    assign n_clamped = (mem.data_in > 16'(MAX_NBR)) ? CNT_W'(MAX_NBR) : mem.data_in[CNT_W-1:0];
    assign state_dbg = state;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state               <= ST_IDLE;
            n                   <= '0;
            i                   <= '0;
            k                   <= '0;
            cur_id              <= '0;
            cur_val             <= '0;
            cur_bid             <= '0;
            mem.address         <= '0;
            mem.data_out        <= '0;
            mem.wr_en           <= 1'b0;
            done_scan           <= 1'b0;
            besthop             <= NO_HOP;
            bestvalue           <= '0;
            bestneighborID      <= NO_HOP;
            betterNeighborCount <= '0;
        end else begin
            mem.wr_en <= 1'b0;
            done_scan <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_scan) begin
                        bestvalue      <= '0;
                        besthop        <= NO_HOP;
                        bestneighborID <= NO_HOP;
                        k              <= '0;
                        i              <= '0;
                        mem.address    <= NBR_CNT_ADDR;
                        state          <= ST_CNT_A;
                    end
                end
                ST_CNT_A: begin
                    mem.address <= NBR_CNT_ADDR;
                    state       <= ST_CNT_RD;
                end
                ST_CNT_RD: begin
                    n <= n_clamped;
                    if (n_clamped == '0) begin
                        mem.address         <= BETTER_CNT;
                        mem.data_out        <= {11'b0, k};
                        mem.wr_en           <= 1'b1;
                        betterNeighborCount <= {11'b0, k};
                        state               <= ST_WR_C;
                    end else begin
                        state <= ST_ID_A;
                    end
                end
                ST_ID_A: begin
                    mem.address <= entry_addr(i);
                    state       <= ST_ID_RD;
                end
                ST_ID_RD: begin
                    cur_id <= mem.data_in;
                    state  <= ST_VAL_A;
                end
                ST_VAL_A: begin
                    mem.address <= entry_addr(i) + 11'd2;
                    state       <= ST_VAL_RD;
                end
                ST_VAL_RD: begin
                    cur_val <= mem.data_in;
                    state   <= ST_BID_A;
                end
                ST_BID_A: begin
                    mem.address <= entry_addr(i) + 11'd4;
                    state       <= ST_BID_RD;
                end
                ST_BID_RD: begin
                    cur_bid <= mem.data_in;
                    state   <= ST_EVAL;
                end
                ST_EVAL: begin
                    // Strict compare keeps the earlier entry on ties; entry 0 always seeds the best.
                    if (cur_val > bestvalue || i == '0) begin
                        besthop        <= cur_id;
                        bestvalue      <= cur_val;
                        bestneighborID <= cur_bid;
                    end
                    if (cur_val > mybest && cur_id != MY_NODE_ID) begin
                        mem.address  <= slot_addr(k);
                        mem.data_out <= cur_id;
                        mem.wr_en    <= 1'b1;
                        state        <= ST_WR_L;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_WR_L: begin
                    k     <= k + 5'd1;
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    i <= i + 5'd1;
                    if (i + 5'd1 < n) begin
                        state <= ST_ID_A;
                    end else begin
                        mem.address         <= BETTER_CNT;
                        mem.data_out        <= {11'b0, k};
                        mem.wr_en           <= 1'b1;
                        betterNeighborCount <= {11'b0, k};
                        state               <= ST_WR_C;
                    end
                end
                ST_WR_C: begin
                    done_scan <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
